ps2_keycode_packer: RTL and testbench
=====================================

// Module: ps2_keycode_packer
// PURPOSE
//  Receives PS/2 keyboard frames (scan-code set 2) and maintains the packed 32-bit held-key
//  word consumed by the sprite/motion logic. Bytes [7:0]..[31:24] hold up to four HID usage
//  codes of currently held keys, packed from byte 0, 0x00 = empty slot. Clk domain; feeds
//  the keycode bus directly, no software in the path.
// PARAMETERS
//  TIMEOUT_CYCLES  50000  Clk cycles without a PS/2 falling edge before a partial frame is aborted
//  SYNC_STAGES     2      flops on ps2_clk/ps2_data before any use (>=2)
// PORTS
//  Clk          in   1   system clock
//  Reset        in   1   asynchronous, active-high reset
//  ps2_clk      in   1   raw PS/2 clock from the pin; async to Clk
//  ps2_data     in   1   raw PS/2 data from the pin; async to Clk
//  keycode      out  32  packed held-key HID codes; slot 0 = byte [7:0]
//  key_changed  out  1   1-cycle pulse on the cycle keycode takes a new value
//  frame_err    out  1   1-cycle pulse on a parity, start, stop or timeout failure
// BEHAVIOUR
//  Reset: keycode=0, key_changed=0, frame_err=0, RX FSM=IDLE, decode FSM=D_IDLE, timeout counter=0.
//  Framing:
//   - Bits are sampled on each synchronized falling edge of ps2_clk: start(0), d0..d7 LSB first,
//     odd parity, stop(1).
//   - RX states: IDLE -> DATA (start bit sampled 0; a 1 stays IDLE) -> PARITY -> STOP -> IDLE.
//   - byte_valid pulses the cycle after the edge that samples a good stop bit.
//   - Parity wrong or stop=0: frame dropped, frame_err pulses, return to IDLE.
//   - Outside IDLE, TIMEOUT_CYCLES cycles with no falling edge: frame dropped, frame_err
//     pulses, return to IDLE. This also resyncs after reset mid-frame.
//  Decode FSM, run on each byte_valid:
//   - D_IDLE: E0->D_EXT; F0->D_BRK; else make(b, ext=0).
//   - D_EXT: F0->D_EXTBRK; else make(b, ext=1) -> D_IDLE.
//   - D_BRK: break(b, 0) -> D_IDLE.   D_EXTBRK: break(b, 1) -> D_IDLE.
//  Translation (set2 -> HID):
//   - Plain codes: 1C->04 A, 23->07 D, 1D->1A W, 1B->16 S, 29->2C Space, 5A->28 Enter.
//   - E0-prefixed: 6B->50 Left, 74->4F Right, 75->52 Up, 72->51 Down.
//   - Anything else, including the E1 pause sequence, maps to 00 and is ignored (FSM still
//     advances).
//  Table update, registered the cycle after byte_valid:
//   - make: if the code is already present (typematic repeat), no change. Else it goes into
//     the lowest empty slot. With all 4 slots full, the make is dropped, no change.
//   - break: the matching slot is removed and higher slots shift down one byte (no holes).
//     Break of a key that is not held: no change.
//   - key_changed pulses only if keycode actually differs from its previous value.
//  Latency: stop-bit edge (synced) -> byte_valid +1 cycle -> keycode/key_changed +1 cycle.
//  Sync adds SYNC_STAGES cycles before the edge.
// STRUCTURE
//  - ps2_pkg: rx_state_t, dec_state_t enums; set-2 and HID constants; function
//    set2_to_hid(input logic ext, input logic [7:0] b) returns logic [7:0].
//  - Sub-module ps2_rx_frame: synchronizer, falling-edge detect, bit shift register, parity,
//    timeout. Outputs byte_valid, byte_data[7:0], frame_err.
//  - Top: decode FSM and slot table (4 x 8-bit regs, combinational insert/compact, registered
//    result).
// TESTING  (TIMEOUT_CYCLES=200, PS/2 bit period 40 Clk)
//  1. Frame 1D (W) -> keycode=0x0000001A, one key_changed; then F0 1D -> keycode=0, one
//     key_changed.
//  2. Make 1D, 1C, 23, 1B, 29 (5 keys):
//     - after 4 makes, keycode=0x16071A04 is wrong; it must be 0x1607041A;
//     - the 5th make is dropped, no key_changed;
//     - F0 1C -> 0x0016071A.
//  3. Make 1C repeated x5 (typematic) -> keycode=0x00000004, exactly one key_changed.
//  4. E0 74 -> 0x0000004F; E0 F0 74 -> 0; plain 74 (unmapped) -> no change; E0 F0 with
//     unmapped byte -> no change.
//  5. Frame 1C with bad parity -> frame_err pulse, keycode unchanged. Next good 1C
//     -> 0x00000004.
//  6. Stop clocking after 4 data bits -> frame_err after 200 cycles. A following good frame
//     decodes. Reset asserted mid-frame -> keycode=0 immediately, outputs low.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types, scan-code constants and the set-2 to HID translation for the PS/2 key packer.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        D_IDLE   = 2'd0,
        D_EXT    = 2'd1,
        D_BRK    = 2'd2,
        D_EXTBRK = 2'd3
    } dec_state_t;

    localparam int unsigned SLOTS  = 4;
    localparam int unsigned BYTE_W = 8;

    // Set-2 prefix bytes
    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

    // Set-2 scan codes
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;

    // HID usage codes
    localparam logic [7:0] HID_NONE  = 8'h00;
    localparam logic [7:0] HID_A     = 8'h04;
    localparam logic [7:0] HID_D     = 8'h07;
    localparam logic [7:0] HID_W     = 8'h1A;
    localparam logic [7:0] HID_S     = 8'h16;
    localparam logic [7:0] HID_SPACE = 8'h2C;
    localparam logic [7:0] HID_ENTER = 8'h28;
    localparam logic [7:0] HID_LEFT  = 8'h50;
    localparam logic [7:0] HID_RIGHT = 8'h4F;
    localparam logic [7:0] HID_UP    = 8'h52;
    localparam logic [7:0] HID_DOWN  = 8'h51;

    // Map a set-2 code (with E0-extension flag) to HID; unsupported codes give HID_NONE
    function automatic logic [7:0] set2_to_hid(input logic ext, input logic [7:0] b);
        logic [7:0] hid;
        hid = HID_NONE;
        if (!ext) begin
            case (b)
                SC_A:     hid = HID_A;
                SC_D:     hid = HID_D;
                SC_W:     hid = HID_W;
                SC_S:     hid = HID_S;
                SC_SPACE: hid = HID_SPACE;
                SC_ENTER: hid = HID_ENTER;
                default:  hid = HID_NONE;
            endcase
        end else begin
            case (b)
                SC_LEFT:  hid = HID_LEFT;
                SC_RIGHT: hid = HID_RIGHT;
                SC_UP:    hid = HID_UP;
                SC_DOWN:  hid = HID_DOWN;
                default:  hid = HID_NONE;
            endcase
        end
        return hid;
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: pin synchronizer, falling-edge sampling, parity/stop check and timeout.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   clk_s;
    logic                   data_s;
    logic                   fall_c;
    logic                   timeout_c;

    rx_state_t              state;
    rx_state_t              state_next;
    logic [TMR_W-1:0]       timer;
    logic [2:0]             bit_cnt;
    logic [7:0]             shreg;
    logic                   par_bit;
    logic                   valid_c;
    logic                   err_c;

    // Synchronize the pins; idle level of both lines is high
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign clk_s     = clk_sync[SYNC_STAGES-1];
    assign data_s    = data_sync[SYNC_STAGES-1];
    assign fall_c    = clk_prev & ~clk_s;
    assign timeout_c = (state != IDLE) && !fall_c && (timer == TMR_W'(TIMEOUT_CYCLES - 1));

    // Cycles since the last falling edge while a frame is in progress
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            timer <= '0;
        end else if (state == IDLE || fall_c) begin
            timer <= '0;
        end else begin
            timer <= timer + TMR_W'(1);
        end
    end

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a timeout overrides any frame progress
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (fall_c && !data_s)              state_next = DATA;
            DATA:    if (fall_c && bit_cnt == 3'd7)      state_next = PARITY;
            PARITY:  if (fall_c)                         state_next = STOP;
            STOP:    if (fall_c)                         state_next = IDLE;
            default:                                     state_next = IDLE;
        endcase
        if (timeout_c) begin
            state_next = IDLE;
        end
    end

    // Frame outcome decided on the stop-bit edge: odd parity over data+parity and stop high
    always_comb begin
        valid_c = 1'b0;
        err_c   = 1'b0;
        if (state == STOP && fall_c) begin
            if (data_s && (^{shreg, par_bit})) begin
                valid_c = 1'b1;
            end else begin
                err_c = 1'b1;
            end
        end
        if (timeout_c) begin
            err_c = 1'b1;
        end
    end

    // Registered pulses
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= valid_c;
            frame_err  <= err_c;
        end
    end

    // Bit shift register, LSB first, plus captured parity bit
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            bit_cnt <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
        end else if (fall_c) begin
            case (state)
                IDLE: bit_cnt <= '0;
                DATA: begin
                    shreg   <= {data_s, shreg[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                end
                PARITY:  par_bit <= data_s;
                default: ;
            endcase
        end
    end

    assign byte_data = shreg;

endmodule

// File: rtl/ps2_keycode_packer.sv
// Set-2 decode FSM and packed four-slot held-key table driving the keycode bus.
module ps2_keycode_packer
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [31:0] keycode,
    output logic        key_changed,
    output logic        frame_err
);

    logic       byte_valid;
    logic [7:0] byte_data;

    dec_state_t dec_state;
    dec_state_t dec_next;
    logic       is_make_c;
    logic       is_break_c;
    logic       ext_c;
    logic [7:0] hid_c;

    logic        found_c;
    logic [1:0]  hit_idx_c;
    logic [1:0]  empty_idx_c;
    logic        full_c;
    logic [31:0] low_mask_c;
    logic [31:0] kc_next;

    ps2_rx_frame #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_rx (
        .Clk        (Clk),
        .Reset      (Reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    // Decode state register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            dec_state <= D_IDLE;
        end else begin
            dec_state <= dec_next;
        end
    end

    // Decode next-state: prefixes E0/F0 steer, everything else completes a key event
    always_comb begin
        dec_next = dec_state;
        if (byte_valid) begin
            case (dec_state)
                D_IDLE: begin
                    if (byte_data == SC_EXT)      dec_next = D_EXT;
                    else if (byte_data == SC_BRK) dec_next = D_BRK;
                end
                D_EXT:   dec_next = (byte_data == SC_BRK) ? D_EXTBRK : D_IDLE;
                D_BRK:   dec_next = D_IDLE;
                D_EXTBRK: dec_next = D_IDLE;
                default: dec_next = D_IDLE;
            endcase
        end
    end

    // Decode outputs: which key event the current byte completes
    always_comb begin
        is_make_c  = 1'b0;
        is_break_c = 1'b0;
        ext_c      = 1'b0;
        if (byte_valid) begin
            case (dec_state)
                D_IDLE:   is_make_c = (byte_data != SC_EXT) && (byte_data != SC_BRK);
                D_EXT: begin
                    is_make_c = (byte_data != SC_BRK);
                    ext_c     = 1'b1;
                end
                D_BRK:    is_break_c = 1'b1;
                D_EXTBRK: begin
                    is_break_c = 1'b1;
                    ext_c      = 1'b1;
                end
                default: ;
            endcase
        end
        hid_c = set2_to_hid(ext_c, byte_data);
    end

    // Slot search: lowest slot matching the code and lowest empty slot
    always_comb begin
        found_c     = 1'b0;
        hit_idx_c   = 2'd0;
        empty_idx_c = 2'd0;
        for (int k = SLOTS - 1; k >= 0; k--) begin
            if (keycode[BYTE_W*k +: BYTE_W] == hid_c) begin
                found_c   = 1'b1;
                hit_idx_c = 2'(k);
            end
            if (keycode[BYTE_W*k +: BYTE_W] == HID_NONE) begin
                empty_idx_c = 2'(k);
            end
        end
        full_c = (keycode[31:24] != HID_NONE);
    end

    // Insert into the first empty slot, or remove a slot and shift higher slots down
    always_comb begin
        kc_next    = keycode;
        low_mask_c = (32'd1 << {hit_idx_c, 3'b000}) - 32'd1;
        if (hid_c != HID_NONE) begin
            if (is_make_c && !found_c && !full_c) begin
                kc_next = keycode | (32'(hid_c) << {empty_idx_c, 3'b000});
            end else if (is_break_c && found_c) begin
                kc_next = (keycode & low_mask_c) | ((keycode >> 8) & ~low_mask_c);
            end
        end
    end

    // Registered table and change pulse
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            keycode     <= '0;
            key_changed <= 1'b0;
        end else begin
            keycode     <= kc_next;
            key_changed <= (kc_next != keycode);
        end
    end

endmodule

// File: tb/tb_ps2_keycode_packer.sv
// Randomized and directed bench for ps2_keycode_packer against a held-key list model.
module tb_ps2_keycode_packer;

    localparam int unsigned TO_CYCLES = 200;
    localparam int unsigned BIT_HALF  = 20;

    logic        Clk;
    logic        Reset;
    logic        ps2_clk;
    logic        ps2_data;
    logic [31:0] keycode;
    logic        key_changed;
    logic        frame_err;

    int n_checks;
    int n_pass;
    int kc_pulses;
    int err_pulses;

    bit [7:0] held[$];
    bit       m_ext;
    bit       m_brk;

    ps2_keycode_packer #(
        .TIMEOUT_CYCLES (TO_CYCLES),
        .SYNC_STAGES    (2)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .keycode     (keycode),
        .key_changed (key_changed),
        .frame_err   (frame_err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Pulse counters sampled away from the active edge
    always @(negedge Clk) begin
        if (key_changed) kc_pulses++;
        if (frame_err)   err_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    function automatic bit [7:0] hid_of(input bit ext, input bit [7:0] b);
        if (!ext) begin
            case (b)
                8'h1C: return 8'h04;
                8'h23: return 8'h07;
                8'h1D: return 8'h1A;
                8'h1B: return 8'h16;
                8'h29: return 8'h2C;
                8'h5A: return 8'h28;
                default: return 8'h00;
            endcase
        end
        case (b)
            8'h6B: return 8'h50;
            8'h74: return 8'h4F;
            8'h75: return 8'h52;
            8'h72: return 8'h51;
            default: return 8'h00;
        endcase
    endfunction

    function automatic bit [31:0] model_word();
        bit [31:0] w;
        w = 32'd0;
        foreach (held[i]) w = w | (32'(held[i]) << (8 * i));
        return w;
    endfunction

    task automatic model_press(input bit [7:0] h);
        if (h == 8'h00) return;
        foreach (held[i]) if (held[i] == h) return;
        if (held.size() < 4) held.push_back(h);
    endtask

    task automatic model_release(input bit [7:0] h);
        if (h == 8'h00) return;
        foreach (held[i]) begin
            if (held[i] == h) begin
                held.delete(i);
                return;
            end
        end
    endtask

    // Prefix-flag view of the keyboard protocol
    task automatic model_byte(input bit [7:0] b);
        if (!m_ext && !m_brk) begin
            if (b == 8'hE0)      m_ext = 1'b1;
            else if (b == 8'hF0) m_brk = 1'b1;
            else                 model_press(hid_of(1'b0, b));
        end else if (m_ext && !m_brk) begin
            if (b == 8'hF0) m_brk = 1'b1;
            else begin
                model_press(hid_of(1'b1, b));
                m_ext = 1'b0;
            end
        end else begin
            model_release(hid_of(m_ext, b));
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    // Drive the first nbits of a frame: start, 8 data LSB first, parity, stop
    task automatic ps2_frame(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            repeat (BIT_HALF) @(posedge Clk);
            ps2_clk = 1'b0;
            repeat (BIT_HALF) @(posedge Clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input string tag);
        bit [31:0] old_w;
        int        kc0;
        int        er0;
        old_w = model_word();
        kc0   = kc_pulses;
        er0   = err_pulses;
        ps2_frame(b, 1'b0, 11);
        repeat (40) @(posedge Clk);
        #1;
        model_byte(b);
        check({tag, " keycode"}, keycode, model_word());
        check({tag, " changed"}, 32'(kc_pulses - kc0), 32'(model_word() != old_w));
        check({tag, " no_err"}, 32'(err_pulses - er0), 32'd0);
    endtask

    task automatic send_bad(input logic [7:0] b, input string tag);
        bit [31:0] old_w;
        int        kc0;
        int        er0;
        old_w = model_word();
        kc0   = kc_pulses;
        er0   = err_pulses;
        ps2_frame(b, 1'b1, 11);
        repeat (40) @(posedge Clk);
        #1;
        check({tag, " err"}, 32'(err_pulses - er0), 32'd1);
        check({tag, " keycode"}, keycode, old_w);
        check({tag, " changed"}, 32'(kc_pulses - kc0), 32'd0);
    endtask

    task automatic key_event(input logic [7:0] code, input bit ext, input bit brk, input string tag);
        if (ext) send_byte(8'hE0, {tag, " E0"});
        if (brk) send_byte(8'hF0, {tag, " F0"});
        send_byte(code, tag);
    endtask

    bit [7:0] rnd_code [12];
    bit       rnd_ext  [12];

    initial begin
        int er0;
        int c;
        n_checks   = 0;
        n_pass     = 0;
        kc_pulses  = 0;
        err_pulses = 0;
        m_ext      = 1'b0;
        m_brk      = 1'b0;
        rnd_code   = '{8'h1C, 8'h23, 8'h1D, 8'h1B, 8'h29, 8'h5A,
                       8'h6B, 8'h74, 8'h75, 8'h72, 8'h15, 8'h74};
        rnd_ext    = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0};

        Reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(posedge Clk);
        #1;
        check("reset keycode", keycode, 32'd0);
        check("reset changed", 32'(key_changed), 32'd0);
        check("reset err", 32'(frame_err), 32'd0);
        Reset = 1'b0;
        repeat (5) @(posedge Clk);

        // Single key press and release
        key_event(8'h1D, 1'b0, 1'b0, "t1 make W");
        check("t1 W word", keycode, 32'h0000001A);
        key_event(8'h1D, 1'b0, 1'b1, "t1 break W");
        check("t1 empty", keycode, 32'h00000000);

        // Fill four slots, drop the fifth, release from the middle
        key_event(8'h1D, 1'b0, 1'b0, "t2 W");
        key_event(8'h1C, 1'b0, 1'b0, "t2 A");
        key_event(8'h23, 1'b0, 1'b0, "t2 D");
        key_event(8'h1B, 1'b0, 1'b0, "t2 S");
        check("t2 four", keycode, 32'h1607041A);
        key_event(8'h29, 1'b0, 1'b0, "t2 fifth");
        check("t2 full", keycode, 32'h1607041A);
        key_event(8'h1C, 1'b0, 1'b1, "t2 break A");
        check("t2 compact", keycode, 32'h0016071A);
        key_event(8'h1D, 1'b0, 1'b1, "t2 clr W");
        key_event(8'h23, 1'b0, 1'b1, "t2 clr D");
        key_event(8'h1B, 1'b0, 1'b1, "t2 clr S");
        check("t2 cleared", keycode, 32'd0);

        // Typematic repeat
        for (int i = 0; i < 5; i++) key_event(8'h1C, 1'b0, 1'b0, "t3 repeat");
        check("t3 word", keycode, 32'h00000004);
        key_event(8'h1C, 1'b0, 1'b1, "t3 release");

        // Extended keys and unmapped codes
        key_event(8'h74, 1'b1, 1'b0, "t4 right");
        check("t4 right word", keycode, 32'h0000004F);
        key_event(8'h74, 1'b1, 1'b1, "t4 right up");
        key_event(8'h74, 1'b0, 1'b0, "t4 plain 74");
        key_event(8'h15, 1'b1, 1'b1, "t4 ext brk unmapped");
        check("t4 word", keycode, 32'd0);

        // Bad parity then recovery
        send_bad(8'h1C, "t5 bad parity");
        key_event(8'h1C, 1'b0, 1'b0, "t5 good A");
        check("t5 word", keycode, 32'h00000004);

        // Timeout on a partial frame
        er0 = err_pulses;
        ps2_frame(8'h1D, 1'b0, 5);
        c = 0;
        while (c < 400 && err_pulses == er0) begin
            @(posedge Clk);
            c++;
        end
        #1;
        check("t6 timeout err", 32'(err_pulses - er0), 32'd1);
        check("t6 timeout not early", 32'(c >= 150), 32'd1);
        check("t6 keycode kept", keycode, model_word());
        repeat (20) @(posedge Clk);
        key_event(8'h23, 1'b0, 1'b0, "t6 after timeout");
        check("t6 word", keycode, 32'h00000704);

        // Randomized key traffic
        for (int n = 0; n < 30; n++) begin
            int k;
            k = $urandom_range(0, 11);
            if ($urandom_range(0, 7) == 0) send_bad(8'($urandom_range(0, 255)), "rnd bad");
            key_event(rnd_code[k], rnd_ext[k], 1'($urandom_range(0, 1)), "rnd");
        end

        // Reset in the middle of a frame
        ps2_frame(8'h5A, 1'b0, 6);
        Reset = 1'b1;
        #1;
        check("t6 rst keycode", keycode, 32'd0);
        check("t6 rst changed", 32'(key_changed), 32'd0);
        check("t6 rst err", 32'(frame_err), 32'd0);
        held.delete();
        m_ext = 1'b0;
        m_brk = 1'b0;
        repeat (5) @(posedge Clk);
        Reset = 1'b0;
        repeat (5) @(posedge Clk);
        key_event(8'h1C, 1'b0, 1'b0, "t6 after reset");
        check("t6 reset word", keycode, 32'h00000004);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
